// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path: segment patterns,
// FSM states and the decode-result record.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Bit order is {a,b,c,d,e,f,g}, segment a in the MSB.
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_OVF   = 7'b0011110;
    localparam seg_t SEG_BLANK = 7'b0000000;

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_VALID = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] digit;
        logic       ovf;
        logic       err;
    } decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a 7-segment pattern back to a hex digit plus
// overflow / illegal-pattern flags.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_t    i_pattern,
    output decode_t o_result
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        o_result = '0;
        case (i_pattern)
            SEG_0:     o_result.digit = 4'h0;
            SEG_1:     o_result.digit = 4'h1;
            SEG_2:     o_result.digit = 4'h2;
            SEG_3:     o_result.digit = 4'h3;
            SEG_4:     o_result.digit = 4'h4;
            SEG_5:     o_result.digit = 4'h5;
            SEG_6:     o_result.digit = 4'h6;
            SEG_7:     o_result.digit = 4'h7;
            SEG_8:     o_result.digit = 4'h8;
            SEG_9:     o_result.digit = 4'h9;
            SEG_A:     o_result.digit = 4'hA;
            SEG_B:     o_result.digit = 4'hB;
            SEG_C:     o_result.digit = 4'hC;
            SEG_D:     o_result.digit = 4'hD;
            SEG_E:     o_result.digit = 4'hE;
            SEG_F:     o_result.digit = 4'hF;
            SEG_OVF:   o_result.ovf   = 1'b1;
            SEG_BLANK: o_result       = '0;
            default:   o_result.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples, debounces and decodes the 7-segment bus, emitting each new glyph
// once on a valid/ready port. Define SEG7_CAPTURE_ERRCNT_EN to add err_count.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seg_a,
    input  logic       seg_b,
    input  logic       seg_c,
    input  logic       seg_d,
    input  logic       seg_e,
    input  logic       seg_f,
    input  logic       seg_g,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_ovf,
    output logic       out_err
`ifdef SEG7_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    seg_t             w_pins;
    seg_t             r_sync [SYNC_STAGES];
    seg_t             w_p;
    seg_t             w_p_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_stable;
    seg_t             r_last;
    state_e           r_state;
    state_e           w_state_next;
    logic             w_emit;
    logic             w_handshake;
    decode_t          w_dec;
    logic [3:0]       r_digit;
    logic             r_ovf;
    logic             r_err;

    assign w_pins   = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
    assign w_p      = r_sync[SYNC_STAGES-1];
    assign w_p_next = r_sync[SYNC_STAGES-2];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the synchronizer array is reset element by element so the
        // first compare after reset sees a known blank, not X.
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SEG_BLANK;
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // neighbour's old value, giving a true shift register.
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // The counter looks at the value about to enter the last stage, so after
    // each edge r_cnt already reflects how long w_p has held its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_p_next != w_p) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_stable = (r_cnt == CNT_MAX);

    seg7_pattern_decode u_decode (
        .i_pattern (w_p),
        .o_result  (w_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_WAIT;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_stable && (w_p != SEG_BLANK) && (w_p != r_last)) begin
                    w_emit       = 1'b1;
                    w_state_next = S_VALID;
                end
            end
            S_VALID: begin
                if (out_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            default: w_state_next = S_WAIT;
        endcase
    end

    // A stable blank forgets the last glyph so a repeated digit re-emits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SEG_BLANK;
        end else if (w_emit) begin
            r_last <= w_p;
        end else if (w_stable && (w_p == SEG_BLANK)) begin
            r_last <= SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_emit) begin
            r_digit <= w_dec.digit;
            r_ovf   <= w_dec.ovf;
            r_err   <= w_dec.err;
        end
    end

    assign out_valid = (r_state == S_VALID);
    assign out_digit = r_digit;
    assign out_ovf   = r_ovf;
    assign out_err   = r_err;

`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_handshake && r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: directed glyph sequences push expected
// transfers; a monitor pops and compares on every valid/ready handshake.
module tb_seg7_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_ovf;
    logic       out_err;
`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    typedef struct packed {
        logic [3:0] digit;
        logic       ovf;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_xfer = 0;

    seg7_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_a     (seg_a),
        .seg_b     (seg_b),
        .seg_c     (seg_c),
        .seg_d     (seg_d),
        .seg_e     (seg_e),
        .seg_f     (seg_f),
        .seg_g     (seg_g),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
`ifdef SEG7_CAPTURE_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_p(input logic [6:0] p);
        {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = p;
    endtask

    task automatic push(input logic [3:0] d, input logic o, input logic e);
        exp_t x;
        x.digit = d;
        x.ovf   = o;
        x.err   = e;
        q.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d transfers still pending after %0d cycles, expected 0",
                     name, q.size(), budget);
            q.delete();
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!out_valid && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(out_valid), 32'd1);
    endtask

    // Counts rising edges from the pin change until out_valid is seen.
    task automatic measure_rise(input string name, input int exp_edges);
        int k;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                k = i;
                break;
            end
        end
        check(name, 32'(k), 32'(exp_edges));
    endtask

    initial begin : monitor
        logic [5:0] prev;
        logic       hold;
        exp_t       e;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || !out_valid) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    n_vec++;
                    if ({out_digit, out_ovf, out_err} !== prev) begin
                        n_err++;
                        $display("FAIL frozen_outputs: got %h, expected %h while stalled",
                                 {out_digit, out_ovf, out_err}, prev);
                    end
                end
                prev = {out_digit, out_ovf, out_err};
                if (out_ready) begin
                    n_xfer++;
                    n_vec++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_transfer: got digit=%h ovf=%b err=%b, expected none",
                                 out_digit, out_ovf, out_err);
                    end else begin
                        e = q.pop_front();
                        if ({out_digit, out_ovf, out_err} !== e) begin
                            n_err++;
                            $display("FAIL transfer: got digit=%h ovf=%b err=%b, expected digit=%h ovf=%b err=%b",
                                     out_digit, out_ovf, out_err, e.digit, e.ovf, e.err);
                        end
                    end
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int x;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_p(7'b0000000);
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_digit", 32'(out_digit), 32'd0);
        check("reset_ovf",   32'(out_ovf),   32'd0);
        check("reset_err",   32'(out_err),   32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("blank_no_emit", 32'(n_xfer), 32'd0);

        // Digit 3 appears on edge 6 and is transferred only once.
        @(negedge clk);
        push(4'h3, 1'b0, 1'b0);
        set_p(7'b1111001);
        measure_rise("latency_3", 6);
        repeat (10) @(negedge clk);
        wait_drain("drain_3", 20);
        repeat (10) @(negedge clk);
        check("single_transfer_3", 32'(n_xfer), 32'd1);

        // Stall on A while the pins move to 1; 1 follows after one bubble.
        @(negedge clk);
        out_ready = 1'b0;
        push(4'hA, 1'b0, 1'b0);
        set_p(7'b1110111);
        wait_valid("valid_A", 20);
        repeat (2) @(negedge clk);
        set_p(7'b0110000);
        push(4'h1, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check("stalled_digit_A", 32'(out_digit), 32'hA);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bubble_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("after_bubble_valid", 32'(out_valid), 32'd1);
        check("after_bubble_digit", 32'(out_digit), 32'h1);
        wait_drain("drain_A1", 20);

        // 4, blank for 5 cycles, 4 again: two transfers; holding adds none.
        @(negedge clk);
        x = n_xfer;
        push(4'h4, 1'b0, 1'b0);
        set_p(7'b0110011);
        repeat (10) @(negedge clk);
        set_p(7'b0000000);
        repeat (5) @(negedge clk);
        push(4'h4, 1'b0, 1'b0);
        set_p(7'b0110011);
        repeat (10) @(negedge clk);
        wait_drain("drain_44", 20);
        repeat (15) @(negedge clk);
        check("repeat_after_blank", 32'(n_xfer - x), 32'd2);

        // Overflow and illegal patterns.
        @(negedge clk);
        push(4'h0, 1'b1, 1'b0);
        set_p(7'b0011110);
        repeat (10) @(negedge clk);
        wait_drain("drain_ovf", 20);
        @(negedge clk);
        push(4'h0, 1'b0, 1'b1);
        set_p(7'b0000001);
        repeat (10) @(negedge clk);
        wait_drain("drain_err", 20);

        // A 3-cycle glitch to 8 between stable 0s is never emitted.
        @(negedge clk);
        push(4'h0, 1'b0, 1'b0);
        set_p(7'b1111110);
        repeat (10) @(negedge clk);
        wait_drain("drain_0", 20);
        repeat (2) @(negedge clk);
        x = n_xfer;
        set_p(7'b1111111);
        repeat (3) @(negedge clk);
        set_p(7'b1111110);
        repeat (15) @(negedge clk);
        check("glitch_no_emit", 32'(n_xfer), 32'(x));

        // Asynchronous reset while stalled in the valid state.
        @(negedge clk);
        out_ready = 1'b0;
        push(4'h5, 1'b0, 1'b0);
        set_p(7'b1011011);
        wait_valid("valid_5", 20);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_digit", 32'(out_digit), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(4'h5, 1'b0, 1'b0);
        measure_rise("latency_after_reset", 6);
        check("reemit_digit_5", 32'(out_digit), 32'h5);
        wait_drain("drain_5", 20);

`ifdef SEG7_CAPTURE_ERRCNT_EN
        // The counter restarted at 0 after the reset above; 300 errors saturate it.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            push(4'h0, 1'b0, 1'b1);
            set_p((i % 2 == 0) ? 7'b0000010 : 7'b0000001);
            wait_drain("drain_errcnt", 30);
        end
        @(posedge clk);
        #1;
        check("err_count_saturated", 32'(err_count), 32'd255);
`endif

        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
